// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 5;
    localparam int SEG_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    // Segment codes {g,f,e,d,c,b,a}, indexed by hex value
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [SEG_W-1:0] SEG_DARK = 8'h00;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit to seven-segment {g..a} decoder, shared by display blocks.
module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // table lookup, every 4-bit value has an entry
    always_comb begin
        seg_o = SEG_CODE[hex_i];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin time-multiplexed scan of a 5-digit seven-segment display with blanking gaps.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   seg_sel,
    output logic [SEG_W-1:0]        seg_data,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 32'd1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 32'd1);

    if ((BLANK_CYC == 32'd0) || (BLANK_CYC >= CLK_DIV) || (CLK_DIV > 32'd1048575)) begin : g_bad_param
        $error("seg_scan_ctrl: BLANK_CYC must be in 1..CLK_DIV-1 and CLK_DIV below 2^20");
    end

    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] dig_snap_q, dig_snap_d;
    logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
    logic [SEG_W-1:0]        seg_data_q, seg_data_d;
    logic                    frame_done_q, frame_done_d;

    logic       idx_ok_s;
    logic [3:0] cur_hex_s;
    logic [6:0] dec_seg_s;
    logic [NUM_DIGITS-1:0] lzb_s;

    assign idx_ok_s = (idx_q <= 3'd4);

    // state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            dig_snap_q   <= '0;
            dp_snap_q    <= '0;
            seg_sel_q    <= '0;
            seg_data_q   <= SEG_DARK;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dig_snap_q   <= dig_snap_d;
            dp_snap_q    <= dp_snap_d;
            seg_sel_q    <= seg_sel_d;
            seg_data_q   <= seg_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // next-state: slot counting, digit rotation, per-frame input snapshot
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dig_snap_d = dig_snap_q;
        dp_snap_d  = dp_snap_q;
        if (!en) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = BLANK;
                    idx_d      = 3'd0;
                    cnt_d      = '0;
                    dig_snap_d = digits;
                    dp_snap_d  = dp_mask;
                end
                BLANK, SHOW: begin
                    if (!idx_ok_s) begin
                        state_d    = BLANK;
                        idx_d      = 3'd0;
                        cnt_d      = '0;
                        dig_snap_d = digits;
                        dp_snap_d  = dp_mask;
                    end else if ((state_q == BLANK) && (cnt_q == BLANK_LAST)) begin
                        state_d = SHOW;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if ((state_q == SHOW) && (cnt_q == SLOT_LAST)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == 3'd4) begin
                            idx_d      = 3'd0;
                            dig_snap_d = digits;
                            dp_snap_d  = dp_mask;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // select the snapshot nibble of the digit being scanned
    always_comb begin
        case (idx_q)
            3'd0:    cur_hex_s = dig_snap_q[3:0];
            3'd1:    cur_hex_s = dig_snap_q[7:4];
            3'd2:    cur_hex_s = dig_snap_q[11:8];
            3'd3:    cur_hex_s = dig_snap_q[15:12];
            3'd4:    cur_hex_s = dig_snap_q[19:16];
            default: cur_hex_s = 4'h0;
        endcase
    end

    seg_hex_decoder u_dec (
        .hex_i (cur_hex_s),
        .seg_o (dec_seg_s)
    );

`ifdef SEG_SCAN_LZB_EN
    // zero run from the top digit downward; digit 0 always stays lit
    always_comb begin
        lzb_s    = '0;
        lzb_s[4] = (dig_snap_q[19:16] == 4'h0);
        lzb_s[3] = lzb_s[4] && (dig_snap_q[15:12] == 4'h0);
        lzb_s[2] = lzb_s[3] && (dig_snap_q[11:8] == 4'h0);
        lzb_s[1] = lzb_s[2] && (dig_snap_q[7:4] == 4'h0);
        lzb_s[0] = 1'b0;
    end
`else
    assign lzb_s = '0;
`endif

    // output decode; dropping en darkens the very next cycle
    always_comb begin
        seg_sel_d    = '0;
        seg_data_d   = SEG_DARK;
        frame_done_d = 1'b0;
        if (en && (state_q == SHOW) && idx_ok_s) begin
            seg_sel_d    = 5'b00001 << idx_q;
            seg_data_d   = {dp_snap_q[idx_q], (lzb_s[idx_q] ? 7'h00 : dec_seg_s)};
            frame_done_d = (idx_q == 3'd4) && (cnt_q == SLOT_LAST);
        end else begin
            seg_sel_d    = '0;
            seg_data_d   = SEG_DARK;
            frame_done_d = 1'b0;
        end
    end

    assign seg_sel    = seg_sel_q;
    assign seg_data   = seg_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_DIV   = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [19:0] digits;
    logic [4:0]  dp_mask;
    logic [4:0]  seg_sel;
    logic [7:0]  seg_data;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .seg_sel    (seg_sel),
        .seg_data   (seg_data),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [19:0]     digits;
        logic [4:0]      dp;
        logic [4:0][7:0] exp;
    } frame_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input logic [4:0] s, input logic [7:0] d, input logic fd);
        check({tag, ".sel"}, {27'd0, seg_sel}, {27'd0, s});
        check({tag, ".data"}, {24'd0, seg_data}, {24'd0, d});
        check({tag, ".fd"}, {31'd0, frame_done}, {31'd0, fd});
    endtask

    // two dark cycles, then nshow cycles of digit k; optionally swap inputs mid-show
    task automatic run_slot(input int k, input logic [7:0] d, input int nshow, input logic chg);
        logic [4:0] sel;
        sel = 5'b00001 << k;
        for (int i = 0; i < 2; i++) begin
            step();
            sample("dark", 5'd0, 8'h00, 1'b0);
        end
        for (int i = 0; i < nshow; i++) begin
            step();
            sample("show", sel, d, (k == 4) && (i == 5));
            if (chg && (i == 2)) digits = 20'hFFFFF;
        end
    endtask

    task automatic run_frame(input logic first, input logic [4:0][7:0] exp);
        if (first) begin
            step();
            sample("start", 5'd0, 8'h00, 1'b0);
        end
        for (int k = 0; k < 5; k++) run_slot(k, exp[k], 6, 1'b0);
    endtask

    frame_vec_t vecs [5];
    logic [4:0][7:0] exp_43210;
    logic [4:0][7:0] exp_f;

    initial begin
        exp_43210 = {8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
        exp_f     = {8'h71, 8'h71, 8'h71, 8'h71, 8'h71};
        vecs[0] = '{digits: 20'h43210, dp: 5'b00000, exp: exp_43210};
        vecs[1] = '{digits: 20'hABCDE, dp: 5'b00101, exp: {8'h77, 8'h7C, 8'hB9, 8'h5E, 8'hF9}};
        vecs[2] = '{digits: 20'h98765, dp: 5'b11010, exp: {8'hEF, 8'hFF, 8'h07, 8'hFD, 8'h6D}};
`ifdef SEG_SCAN_LZB_EN
        vecs[3] = '{digits: 20'h00700, dp: 5'b00000, exp: {8'h00, 8'h00, 8'h07, 8'h3F, 8'h3F}};
        vecs[4] = '{digits: 20'h00000, dp: 5'b10000, exp: {8'h80, 8'h00, 8'h00, 8'h00, 8'h3F}};
`else
        vecs[3] = '{digits: 20'h00700, dp: 5'b00000, exp: {8'h3F, 8'h3F, 8'h07, 8'h3F, 8'h3F}};
        vecs[4] = '{digits: 20'h00000, dp: 5'b10000, exp: {8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
`endif

        // reset held with en high keeps everything dark
        rst     = 1'b1;
        en      = 1'b1;
        digits  = 20'h43210;
        dp_mask = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            step();
            sample("reset", 5'd0, 8'h00, 1'b0);
        end
        rst = 1'b0;
        run_frame(1'b1, exp_43210);

        // snapshot: inputs change while digit 2 is shown
        run_slot(0, 8'h3F, 6, 1'b0);
        run_slot(1, 8'h06, 6, 1'b0);
        run_slot(2, 8'h5B, 6, 1'b1);
        run_slot(3, 8'h4F, 6, 1'b0);
        run_slot(4, 8'h66, 6, 1'b0);
        run_frame(1'b0, exp_f);

        // table of full frames, each started from IDLE
        for (int v = 0; v < 5; v++) begin
            en = 1'b0;
            step();
            sample("idle", 5'd0, 8'h00, 1'b0);
            digits  = vecs[v].digits;
            dp_mask = vecs[v].dp;
            en      = 1'b1;
            run_frame(1'b1, vecs[v].exp);
        end

        // abort during digit 3, then restart from digit 0
        en = 1'b0;
        step();
        sample("idle", 5'd0, 8'h00, 1'b0);
        digits  = 20'h43210;
        dp_mask = 5'b00000;
        en      = 1'b1;
        step();
        sample("start", 5'd0, 8'h00, 1'b0);
        run_slot(0, 8'h3F, 6, 1'b0);
        run_slot(1, 8'h06, 6, 1'b0);
        run_slot(2, 8'h5B, 6, 1'b0);
        run_slot(3, 8'h4F, 3, 1'b0);
        en = 1'b0;
        step();
        sample("abort", 5'd0, 8'h00, 1'b0);
        step();
        sample("abort_hold", 5'd0, 8'h00, 1'b0);
        en = 1'b1;
        run_frame(1'b1, exp_43210);

        // en dropped on the edge that would raise frame_done
        run_slot(0, 8'h3F, 6, 1'b0);
        run_slot(1, 8'h06, 6, 1'b0);
        run_slot(2, 8'h5B, 6, 1'b0);
        run_slot(3, 8'h4F, 6, 1'b0);
        run_slot(4, 8'h66, 5, 1'b0);
        en = 1'b0;
        step();
        sample("fd_suppress", 5'd0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            sample("off", 5'd0, 8'h00, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler for the shared 5-digit seven-segment display.
- Accepts five 4-bit digit values and grants the single seg_data bus to one digit at a time, in a fixed round-robin.
- Inserts a blanking gap between digit slots to suppress ghosting.
- Sits between the counter/datapath logic and the board display pins; replaces ad-hoc static drive of seg_sel/seg_data.

Parameters:
- CLK_DIV, 50000, total clk cycles per digit slot (blank + show); legal range BLANK_CYC+1 .. 2^20-1.
- BLANK_CYC, 16, cycles at the start of each slot with the display dark; must be >= 1 and < CLK_DIV (elaboration-time check).

Ports:
- clk  input  1  system clock, single clock domain, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable; 0 forces the display dark and restarts the scan.
- digits  input  20  digit n occupies bits [4n+3:4n]; digit 4 is most significant.
- dp_mask  input  5  bit n lights the decimal point of digit n.
- seg_sel  output  5  one-hot digit select, active-high; all-zero means dark.
- seg_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- frame_done  output  1  one-cycle pulse at the end of each full 5-digit frame.

Behaviour:
- Clocking and outputs:
  - Single clock; reset is synchronous and active-high.
  - All outputs are registered.
- Reset: state=IDLE, idx=0, slot counter=0, seg_sel=0, seg_data=0, frame_done=0, snapshot registers=0.
- FSM states IDLE, BLANK, SHOW:
  - IDLE: outputs dark. en=1 moves to BLANK with idx=0 and cnt=0 on the next cycle.
  - BLANK: seg_sel=0, seg_data=0; cnt increments. When cnt=BLANK_CYC-1, go to SHOW.
  - SHOW: seg_sel = (1<<idx), seg_data = decode(snapshot digit idx) | (dp_snap[idx]<<7); cnt increments.
  - At cnt=CLK_DIV-1 in SHOW: cnt=0, idx=(idx==4)?0:idx+1, go to BLANK.
- Latency: first non-zero seg_sel appears BLANK_CYC+1 cycles after en is first sampled high in IDLE.
- Snapshot: digits and dp_mask are captured on every transition into BLANK with idx=0, i.e. once per frame. Input changes mid-frame never tear the display.
- frame_done: high for exactly one cycle, on the cycle the FSM leaves SHOW with idx=4.
- Wrap-around: idx 4 goes to 0 with no extra gap beyond the normal BLANK.
- en=0 in any state: next cycle IDLE, idx=0, cnt=0, outputs dark, frame_done=0. A frame_done pending on that same edge is suppressed.
- rst has priority over en.
- Decode table (hex):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Widths: cnt is ceil(log2(CLK_DIV)) bits; idx is 3 bits. Values 5-7 of idx are unreachable; if reached, go to BLANK with idx=0.

Optional Feature:
- SEG_SCAN_LZB_EN defined: leading-zero blanking.
  - Starting at digit 4 and moving downward, digits whose snapshot value is 0 drive segments a-g to 0 until the first non-zero digit.
  - Digit 0 is never blanked.
  - dp still follows dp_snap.
  - seg_sel timing is unchanged.
- Not defined: every digit is decoded normally.

Decomposition:
- Package seg_scan_pkg:
  - NUM_DIGITS=5 and SEG_W=8.
  - State enum typedef {IDLE,BLANK,SHOW}.
  - 16-entry segment code constants.
  - SEG_DARK=8'h00.
- Sub-module seg_hex_decoder: combinational, 4-bit in, 7-bit out. It is reused by other display blocks.

Test Plan:
All scenarios use CLK_DIV=8 and BLANK_CYC=2.
- Reset: rst=1 for 3 cycles with en=1 -> seg_sel=0, seg_data=0, frame_done=0 throughout; after release, first seg_sel=5'b00001 exactly 3 cycles later.
- Scan order: digits=20'h43210, dp_mask=0 -> per digit, 2 dark cycles then 6 cycles of seg_sel 00001/3F, 00010/06, 00100/5B, 01000/4F, 10000/66; frame_done every 40 cycles.
- Snapshot: change digits to 20'hFFFFF mid-frame while digit 2 is shown -> the rest of that frame shows 5B, 4F, 66; the next frame shows 71 on all digits.
- dp and hex: digits=20'hABCDE, dp_mask=5'b00101 -> seg_data for digits 0,1,2 = F9, 5E, B9.
- Abort: drop en during SHOW of digit 3 -> next cycle seg_sel=0 and no frame_done; re-enable -> restarts at digit 0 after 2 dark cycles.
- With SEG_SCAN_LZB_EN: digits=20'h00700 -> digits 4,3 show seg_data=00; digits 2,1,0 show 07, 3F, 3F. With digits=0, digit 0 shows 3F.
